// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - single-beat AXI master shared by the fetch and data ports
module axi_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                i_stall,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                d_stall,
  input  logic                longest_stall,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_AR   = 3'd1,
    S_D_R    = 3'd2,
    S_D_AW_W = 3'd3,
    S_D_B    = 3'd4,
    S_I_AR   = 3'd5,
    S_I_R    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

  // Only one transaction is ever in flight, so the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = ^rid;

  assign i_stall    = inst_en & ~i_done_q;
  assign d_stall    = data_en & ~d_done_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign arvalid = (state_q == S_D_AR) || (state_q == S_I_AR);
  assign arid    = (state_q == S_I_AR) ? ID_W'(INST_ID) : ID_W'(DATA_ID);
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arlen   = 8'd0;
  assign arburst = 2'd1;
  assign rready  = (state_q == S_D_R) || (state_q == S_I_R);

  assign awvalid = (state_q == S_D_AW_W) && !aw_done_q;
  assign awid    = ID_W'(DATA_ID);
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awlen   = 8'd0;
  assign awburst = 2'd1;
  assign wvalid  = (state_q == S_D_AW_W) && !w_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign bready  = (state_q == S_D_B);

  // Next-state: arbitration in IDLE, channel handshakes, done-flag bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    // A finished result is held until the whole pipeline advances.
    i_done_d     = i_done_q & longest_stall;
    d_done_d     = d_done_q & longest_stall;
    case (state_q)
      S_IDLE: begin
        if (data_en && !d_done_q) begin
          addr_d    = data_addr;
          size_d    = data_size;
          wdata_d   = data_wdata;
          wstrb_d   = data_wen;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (data_wen == '0) ? S_D_AR : S_D_AW_W;
        end else if (inst_en && !i_done_q) begin
          addr_d  = inst_addr;
          size_d  = 2'd2;
          state_d = S_I_AR;
        end
      end
      S_D_AR: if (arready) state_d = S_D_R;
      S_I_AR: if (arready) state_d = S_I_R;
      S_D_R: begin
        if (rvalid) begin
          state_d = S_IDLE;
          // A request flushed meanwhile still drains the beat but keeps no result.
          if (data_en) begin
            d_done_d     = 1'b1;
            data_rdata_d = rdata;
          end
        end
      end
      S_I_R: begin
        if (rvalid) begin
          state_d = S_IDLE;
          if (inst_en) begin
            i_done_d     = 1'b1;
            inst_rdata_d = rdata;
          end
        end
      end
      S_D_AW_W: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_D_B;
      end
      S_D_B: begin
        if (bvalid) begin
          state_d = S_IDLE;
          if (data_en) d_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset drops every bus valid/ready at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule
